// File: rtl/srl_delay_ctrl_pkg.sv
// Shared types for the SRL delay-line controller.
//   ctrl_state_e : controller phase (prime the lines, idle, calibration sweep)
package srl_delay_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_SWEEP = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/srl_delay_ctrl_strobe.sv
// strobe_counter: counts en pulses, saturating at TERM.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : count strobe
//   clr        : synchronous clear, wins over en
//   term       : combinational pulse, en seen while the count sits at TERM
module strobe_counter #(
   parameter int         W    = 4,
   parameter logic [W-1:0] TERM = '1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic term
);

   logic [W-1:0] cnt;

   assign term = en & (cnt == TERM);

   always_ff @(posedge clk) begin
      if (!rst_n || clr)
         cnt <= '0;
      else if (en && cnt != TERM)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/srl_delay_ctrl.sv
// srl_delay_ctrl: owns the tap addresses of CHANNELS SRL delay lines.
//   clk, rst_n          : clock, synchronous active-low reset
//   en / sr_ce          : sample strobe, passed straight through as the shared ce
//   taps, taps_valid    : flat tap array (channel i at [i*ABITS +: ABITS]), lines primed
//   wr_*                : single-entry delay write port, committed on the next en edge
//   sweep_start/chan    : calibration sweep of one channel through every tap
//   sweep_abort         : restore the saved tap at the next en and finish
//   busy, step, step_tap, done : sweep / write status
module srl_delay_ctrl
   import srl_delay_ctrl_pkg::*;
#(
   parameter int CHANNELS = 24,
   parameter int CBITS    = 5,
   parameter int ABITS    = 4,
   parameter int DWELL    = 1024,
   parameter int DBITS    = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   output logic                      sr_ce,
   output logic [CHANNELS*ABITS-1:0] taps,
   output logic                      taps_valid,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [CBITS-1:0]          wr_chan,
   input  logic [ABITS-1:0]          wr_tap,
   input  logic                      sweep_start,
   input  logic [CBITS-1:0]          sweep_chan,
   input  logic                      sweep_abort,
   output logic                      busy,
   output logic                      step,
   output logic [ABITS-1:0]          step_tap,
   output logic                      done
);

   localparam logic [ABITS-1:0] TAP_MAX    = '1;
   localparam logic [DBITS-1:0] DWELL_LAST = DBITS'(DWELL - 1);
   localparam logic [CBITS:0]   CH_LIM     = (CBITS+1)'(CHANNELS);

   ctrl_state_e                      state;
   logic [CHANNELS-1:0][ABITS-1:0]   tap_q;
   logic                             pending;
   logic [CBITS-1:0]                 stg_chan;
   logic [ABITS-1:0]                 stg_tap;
   logic [CBITS-1:0]                 sw_chan;
   logic [ABITS-1:0]                 sw_saved;
   logic                             sw_init;   // first en of the sweep still to come
   logic                             abort_q;

   logic fill_term, dwell_term, dwell_clr;
   logic wr_fire, wr_commit, sweep_ok, wr_chan_ok;
   logic sw_abort_now, sw_step, sw_last, sw_wr;
   logic [ABITS-1:0] sw_cur, sw_val;

   assign sr_ce      = en;
   assign taps       = tap_q;
   assign busy       = (state == ST_SWEEP) | pending;
   assign wr_ready   = rst_n & ~pending & (state != ST_SWEEP) &
                       ~((state == ST_IDLE) & sweep_start);
   assign wr_fire    = wr_valid & wr_ready;
   assign wr_commit  = pending & en;
   assign sweep_ok   = {1'b0, sweep_chan} < CH_LIM;
   assign wr_chan_ok = {1'b0, wr_chan} < CH_LIM;

   // Sweep commit decode: abort wins, then the initial zero, then a dwell step.
   always_comb begin
      sw_cur       = tap_q[sw_chan];
      sw_abort_now = (state == ST_SWEEP) & en & (abort_q | sweep_abort);
      sw_step      = (state == ST_SWEEP) & ~sw_abort_now & ~sw_init & dwell_term;
      sw_last      = sw_step & (sw_cur == TAP_MAX);
      sw_wr        = sw_abort_now | ((state == ST_SWEEP) & en & sw_init) | sw_step;
      if (sw_abort_now || sw_last) sw_val = sw_saved;
      else if (sw_init)            sw_val = '0;
      else                         sw_val = sw_cur + 1'b1;
   end

   assign dwell_clr = (state != ST_SWEEP) | sw_init | sw_step | sw_abort_now;

   strobe_counter #(.W(ABITS), .TERM(TAP_MAX)) u_fill (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(state != ST_FILL), .term(fill_term)
   );

   strobe_counter #(.W(DBITS), .TERM(DWELL_LAST)) u_dwell (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(dwell_clr), .term(dwell_term)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_FILL;
         tap_q      <= '0;
         taps_valid <= 1'b0;
         pending    <= 1'b0;
         stg_chan   <= '0;
         stg_tap    <= '0;
         sw_chan    <= '0;
         sw_saved   <= '0;
         sw_init    <= 1'b0;
         abort_q    <= 1'b0;
         step       <= 1'b0;
         step_tap   <= '0;
         done       <= 1'b0;
      end else begin
         step <= 1'b0;
         done <= 1'b0;

         // Acceptance needs !pending, so the accepting edge never commits.
         if (wr_commit) pending <= 1'b0;
         if (wr_fire && wr_chan_ok) begin
            pending  <= 1'b1;
            stg_chan <= wr_chan;
            stg_tap  <= wr_tap;
         end

         // Per-channel decode; a sweep commit to the same channel overrides a write.
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_commit && stg_chan == CBITS'(i)) tap_q[i] <= stg_tap;
            if (sw_wr && sw_chan == CBITS'(i))      tap_q[i] <= sw_val;
         end

         case (state)
            ST_FILL: begin
               if (fill_term) begin
                  taps_valid <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (sweep_start && sweep_ok) begin
                  sw_chan  <= sweep_chan;
                  sw_saved <= tap_q[sweep_chan];
                  sw_init  <= 1'b1;
                  abort_q  <= 1'b0;
                  state    <= ST_SWEEP;
               end
            end
            ST_SWEEP: begin
               if (sweep_abort) abort_q <= 1'b1;
               if (en) sw_init <= 1'b0;
               if (sw_step) begin
                  step     <= 1'b1;
                  step_tap <= sw_cur;
               end
               if (sw_abort_now || sw_last) begin
                  done    <= 1'b1;
                  abort_q <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_srl_delay_ctrl.sv
// Randomized + directed bench for srl_delay_ctrl against a behavioural model.
module tb_srl_delay_ctrl;

   localparam int CH = 24;
   localparam int CB = 5;
   localparam int AB = 4;
   localparam int DW = 4;
   localparam int DB = 2;
   localparam int NT = 16;

   logic              clk = 1'b0;
   logic              rst_n, en, sr_ce, taps_valid;
   logic [CH*AB-1:0]  taps;
   logic              wr_valid, wr_ready;
   logic [CB-1:0]     wr_chan, sweep_chan;
   logic [AB-1:0]     wr_tap, step_tap;
   logic              sweep_start, sweep_abort, busy, step, done;

   always #5 clk = ~clk;

   srl_delay_ctrl #(.CHANNELS(CH), .CBITS(CB), .ABITS(AB), .DWELL(DW), .DBITS(DB)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sr_ce(sr_ce), .taps(taps), .taps_valid(taps_valid),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan), .wr_tap(wr_tap),
      .sweep_start(sweep_start), .sweep_chan(sweep_chan), .sweep_abort(sweep_abort),
      .busy(busy), .step(step), .step_tap(step_tap), .done(done)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: mode 0=priming, 1=idle, 2=sweeping. Sweep position is derived from
   // the number of en pulses seen since the sweep started.
   int  m_mode, m_fill, m_pch, m_ptap, m_sch, m_saved, m_sens, e_step_tap;
   int  m_taps[CH];
   bit  m_valid, m_pend, m_abort, e_step, e_done;

   task automatic model_reset();
      m_mode = 0; m_fill = 0; m_valid = 0; m_pend = 0; m_abort = 0;
      e_step = 0; e_done = 0; e_step_tap = 0; m_sens = 0;
      for (int i = 0; i < CH; i++) m_taps[i] = 0;
   endtask

   function automatic logic [CH*AB-1:0] pack_taps();
      logic [CH*AB-1:0] v;
      v = '0;
      for (int i = 0; i < CH; i++) v[i*AB +: AB] = AB'(m_taps[i]);
      return v;
   endfunction

   task automatic model_step(input bit r, input bit e, input bit wv, input int wc, input int wt,
                             input bit ss, input int sc, input bit sa);
      int old[CH];
      bit rdy;
      int k;
      if (!r) begin
         model_reset();
         return;
      end
      old    = m_taps;
      e_step = 0;
      e_done = 0;
      rdy    = !m_pend && m_mode != 2 && !(m_mode == 1 && ss);
      if (m_pend && e) begin
         m_taps[m_pch] = m_ptap;
         m_pend = 0;
      end
      if (wv && rdy && wc < CH) begin
         m_pend = 1; m_pch = wc; m_ptap = wt;
      end
      case (m_mode)
         0: if (e) begin
               m_fill++;
               if (m_fill == NT) begin m_valid = 1; m_mode = 1; end
            end
         1: if (ss && sc < CH) begin
               m_sch = sc; m_saved = old[sc]; m_sens = 0; m_abort = 0; m_mode = 2;
            end
         default: begin
            if (sa) m_abort = 1;
            if (e) begin
               m_sens++;
               if (m_abort) begin
                  m_taps[m_sch] = m_saved; e_done = 1; m_mode = 1;
               end else if (m_sens == 1) begin
                  m_taps[m_sch] = 0;
               end else if ((m_sens - 1) % DW == 0) begin
                  k = (m_sens - 1) / DW - 1;
                  e_step = 1; e_step_tap = k;
                  if (k == NT - 1) begin
                     m_taps[m_sch] = m_saved; e_done = 1; m_mode = 1;
                  end else begin
                     m_taps[m_sch] = k + 1;
                  end
               end
            end
         end
      endcase
   endtask

   // One clock: drive at negedge, check comb outputs, then registered outputs after the edge.
   task automatic cyc(input bit r, input bit e, input bit wv, input int wc, input int wt,
                      input bit ss, input int sc, input bit sa);
      @(negedge clk);
      rst_n = r; en = e; wr_valid = wv; wr_chan = CB'(wc); wr_tap = AB'(wt);
      sweep_start = ss; sweep_chan = CB'(sc); sweep_abort = sa;
      #1;
      chk("sr_ce", sr_ce, e);
      chk("wr_ready", wr_ready, r && !m_pend && m_mode != 2 && !(m_mode == 1 && ss));
      chk("busy", busy, (m_mode == 2) || m_pend);
      @(posedge clk);
      model_step(r, e, wv, wc, wt, ss, sc, sa);
      #1;
      chk("taps", taps, pack_taps());
      chk("taps_valid", taps_valid, m_valid);
      chk("step", step, e_step);
      chk("done", done, e_done);
      if (e_step) chk("step_tap", step_tap, e_step_tap);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; wr_valid = 1'b0; wr_chan = '0; wr_tap = '0;
      sweep_start = 1'b0; sweep_chan = '0; sweep_abort = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();

      // Reset state, then prime with en every second clock.
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 36; i++) cyc(1, i % 2, 0, 0, 0, 0, 0, 0);

      // Write ch3=9, en arrives five clocks later.
      cyc(1, 0, 1, 3, 9, 0, 0, 0);
      repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);

      // Write with en on the accepting edge; second write stalls until the commit.
      cyc(1, 1, 1, 5, 2, 0, 0, 0);
      cyc(1, 0, 1, 6, 11, 0, 0, 0);
      cyc(1, 0, 1, 6, 11, 0, 0, 0);
      cyc(1, 1, 1, 6, 11, 0, 0, 0);
      cyc(1, 0, 1, 6, 11, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      // Out-of-range channel is discarded.
      cyc(1, 0, 1, 27, 3, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);

      // Full sweep of ch0 with saved tap 7.
      cyc(1, 1, 1, 0, 7, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 70; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);

      // Sweep ch2, abort after step_tap=5; sweep_start beats a write.
      cyc(1, 0, 1, 4, 4, 1, 2, 0);
      for (int i = 0; i < 27; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
      // Out-of-range sweep channel ignored.
      cyc(1, 1, 0, 0, 0, 1, 25, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);

      // Reset mid-sweep.
      cyc(1, 0, 0, 0, 0, 1, 3, 0);
      for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 599) != 0),
             $urandom_range(0, 1),
             ($urandom_range(0, 2) == 0),
             int'($urandom_range(0, 31)),
             int'($urandom_range(0, 15)),
             ($urandom_range(0, 19) == 0),
             int'($urandom_range(0, 27)),
             ($urandom_range(0, 299) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
